memoria_instrucoes_carregavel: RTL and testbench



---
 rtl/memoria_instrucoes_carregavel.sv | 134 +++++++++++++
 tb/tb_memoria_instrucoes_carregavel.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_instrucoes_carregavel.sv
// Loadable instruction memory: program streamed in over a valid/ready port,
// registered fetch with out-of-program address flagging.
module memoria_instrucoes_carregavel #(
    parameter int LARGURA       = 32,
    parameter int PROFUNDIDADE  = 1024,
    parameter int LARGURA_END   = 32,
    parameter int ENDERECO_BASE = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [LARGURA_END-1:0]            endereco,
    input  logic                              ler,
    output logic [LARGURA-1:0]                instrucao,
    output logic                              instrucao_valida,
    output logic                              erro_endereco,
    input  logic [LARGURA-1:0]                carga_dado,
    input  logic                              carga_valido,
    input  logic                              carga_fim,
    output logic                              carga_pronto,
    input  logic                              recarga,
    output logic                              pronta,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] tamanho_programa
);

    localparam int LP = $clog2(PROFUNDIDADE + 1);
    localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int LC = ((LARGURA_END > LP) ? LARGURA_END : LP) + 1;

    localparam logic [LP-1:0] PTR_BASE = LP'(ENDERECO_BASE);
    localparam logic [LP-1:0] ULTIMO   = LP'(PROFUNDIDADE - 1);
    localparam logic [LP-1:0] PROF_L   = LP'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        VAZIA,
        CARREGANDO,
        PRONTA
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [LP-1:0]       ptr_q, ptr_d;
    logic [LP-1:0]       tam_q, tam_d;
    logic [LARGURA-1:0]  instr_q, instr_d;
    logic                valida_q, valida_d;
    logic                erro_q, erro_d;

    logic [LARGURA-1:0]  mem [PROFUNDIDADE];

    logic                aceita;
    logic                ultimo_beat;
    logic                no_alcance;
    logic [LC-1:0]       end_ext, lim_inf, lim_sup;

    always_comb begin
        carga_pronto = 1'b0;
        unique case (estado_q)
            VAZIA:      carga_pronto = 1'b1;
            CARREGANDO: carga_pronto = (ptr_q < PROF_L);
            default:    carga_pronto = 1'b0;
        endcase
    end

    // recarga wins over a simultaneous beat, so that beat is never written
    assign aceita      = carga_valido && carga_pronto && !recarga;
    assign ultimo_beat = carga_fim || (ptr_q == ULTIMO);

    // Widened compare so neither the base offset nor upper address bits wrap
    assign end_ext    = LC'(endereco);
    assign lim_inf    = LC'(ENDERECO_BASE);
    assign lim_sup    = lim_inf + LC'(tam_q);
    assign no_alcance = (estado_q == PRONTA) &&
                        (end_ext >= lim_inf) && (end_ext < lim_sup);

    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        tam_d    = tam_q;
        if (recarga) begin
            estado_d = VAZIA;
            ptr_d    = PTR_BASE;
            tam_d    = '0;
        end else if (aceita) begin
            ptr_d    = ptr_q + 1'b1;
            tam_d    = tam_q + 1'b1;
            estado_d = ultimo_beat ? PRONTA : CARREGANDO;
        end
    end

    always_comb begin
        instr_d  = instr_q;
        valida_d = 1'b0;
        erro_d   = erro_q;
        if (ler) begin
            valida_d = 1'b1;
            if (no_alcance) begin
                instr_d = mem[IW'(endereco)];
                erro_d  = 1'b0;
            end else begin
                instr_d = '0;
                erro_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= VAZIA;
            ptr_q    <= PTR_BASE;
            tam_q    <= '0;
            instr_q  <= '0;
            valida_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
            tam_q    <= tam_d;
            instr_q  <= instr_d;
            valida_q <= valida_d;
            erro_q   <= erro_d;
        end
    end

    always_ff @(posedge clock) begin
        if (aceita) begin
            mem[IW'(ptr_q)] <= carga_dado;
        end
    end

    assign instrucao        = instr_q;
    assign instrucao_valida = valida_q;
    assign erro_endereco    = erro_q;
    assign pronta           = (estado_q == PRONTA);
    assign tamanho_programa = tam_q;

endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
// Directed bench for memoria_instrucoes_carregavel: default, depth-4 and
// base-1 instances share stimulus; each task checks the instance it targets.
module tb_memoria_instrucoes_carregavel;

    logic        clock;
    logic        reset_n;
    logic [31:0] endereco;
    logic        ler;
    logic [31:0] carga_dado;
    logic        carga_valido;
    logic        carga_fim;
    logic        recarga;

    logic [31:0] a_instr, b_instr, c_instr;
    logic        a_val, b_val, c_val;
    logic        a_err, b_err, c_err;
    logic        a_cp, b_cp, c_cp;
    logic        a_pr, b_pr, c_pr;
    logic [10:0] a_tam;
    logic [2:0]  b_tam;
    logic [10:0] c_tam;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [6] = '{32'hC8000014, 32'hC8800004, 32'h78220000,
                              32'hC8400004, 32'hD0410000, 32'hA0800000};

    memoria_instrucoes_carregavel #(
        .LARGURA(32), .PROFUNDIDADE(1024), .LARGURA_END(32), .ENDERECO_BASE(0)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .endereco(endereco), .ler(ler),
        .instrucao(a_instr), .instrucao_valida(a_val), .erro_endereco(a_err),
        .carga_dado(carga_dado), .carga_valido(carga_valido),
        .carga_fim(carga_fim), .carga_pronto(a_cp), .recarga(recarga),
        .pronta(a_pr), .tamanho_programa(a_tam)
    );

    memoria_instrucoes_carregavel #(
        .LARGURA(32), .PROFUNDIDADE(4), .LARGURA_END(32), .ENDERECO_BASE(0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .endereco(endereco), .ler(ler),
        .instrucao(b_instr), .instrucao_valida(b_val), .erro_endereco(b_err),
        .carga_dado(carga_dado), .carga_valido(carga_valido),
        .carga_fim(carga_fim), .carga_pronto(b_cp), .recarga(recarga),
        .pronta(b_pr), .tamanho_programa(b_tam)
    );

    memoria_instrucoes_carregavel #(
        .LARGURA(32), .PROFUNDIDADE(1024), .LARGURA_END(32), .ENDERECO_BASE(1)
    ) dut_c (
        .clock(clock), .reset_n(reset_n), .endereco(endereco), .ler(ler),
        .instrucao(c_instr), .instrucao_valida(c_val), .erro_endereco(c_err),
        .carga_dado(carga_dado), .carga_valido(carga_valido),
        .carga_fim(carga_fim), .carga_pronto(c_cp), .recarga(recarga),
        .pronta(c_pr), .tamanho_programa(c_tam)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic fim);
        carga_dado   = d;
        carga_valido = 1'b1;
        carga_fim    = fim;
        tick();
        carga_valido = 1'b0;
        carga_fim    = 1'b0;
    endtask

    task automatic do_recarga();
        recarga = 1'b1;
        tick();
        recarga = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (a_pr !== 1'b0 || a_tam !== 11'd0 || a_val !== 1'b0 ||
            a_err !== 1'b0 || a_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: pr=%b tam=%0d val=%b err=%b instr=%h, want 0s",
                     a_pr, a_tam, a_val, a_err, a_instr);
        end
        n_checks++;
        if (a_cp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_carga_pronto: got %b want 1", a_cp);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load6();
        for (int i = 0; i < 6; i++) begin
            beat(prog[i], i == 5);
            n_checks++;
            if (a_tam !== 11'(i + 1) || a_pr !== (i == 5)) begin
                n_fail++;
                $display("FAIL load6_beat%0d: tam=%0d pr=%b, want tam=%0d pr=%b",
                         i, a_tam, a_pr, i + 1, i == 5);
            end
        end
        n_checks++;
        if (a_cp !== 1'b0) begin
            n_fail++;
            $display("FAIL load6_cp_pronta: got %b want 0", a_cp);
        end
        for (int i = 0; i < 6; i++) begin
            ler      = 1'b1;
            endereco = 32'(i);
            tick();
            n_checks++;
            if (a_instr !== prog[i] || a_err !== 1'b0 || a_val !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch%0d: instr=%h err=%b val=%b, want %h 0 1",
                         i, a_instr, a_err, a_val, prog[i]);
            end
        end
        ler = 1'b0;
        tick();
        n_checks++;
        if (a_instr !== prog[5] || a_val !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: instr=%h val=%b, want %h 0",
                     a_instr, a_val, prog[5]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2] = '{32'd6, 32'h80000000};
        for (int i = 0; i < 2; i++) begin
            ler      = 1'b1;
            endereco = addrs[i];
            tick();
            n_checks++;
            if (a_instr !== 32'h0 || a_err !== 1'b1 || a_val !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_%h: instr=%h err=%b val=%b, want 0 1 1",
                         addrs[i], a_instr, a_err, a_val);
            end
        end
        ler = 1'b0;
        tick();
    endtask

    task automatic test_depth4();
        do_recarga();
        for (int k = 0; k < 5; k++) begin
            carga_dado   = prog[k];
            carga_valido = 1'b1;
            carga_fim    = 1'b0;
            #1;
            n_checks++;
            if (b_cp !== (k < 4)) begin
                n_fail++;
                $display("FAIL depth4_cp_beat%0d: got %b want %b", k, b_cp, k < 4);
            end
            tick();
        end
        carga_valido = 1'b0;
        n_checks++;
        if (b_pr !== 1'b1 || b_tam !== 3'd4) begin
            n_fail++;
            $display("FAIL depth4_full: pr=%b tam=%0d, want 1 4", b_pr, b_tam);
        end
        ler      = 1'b1;
        endereco = 32'd3;
        tick();
        n_checks++;
        if (b_instr !== prog[3] || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL depth4_mem3: instr=%h err=%b, want %h 0",
                     b_instr, b_err, prog[3]);
        end
        endereco = 32'd4;
        tick();
        n_checks++;
        if (b_instr !== 32'h0 || b_err !== 1'b1) begin
            n_fail++;
            $display("FAIL depth4_addr4: instr=%h err=%b, want 0 1", b_instr, b_err);
        end
        ler = 1'b0;
        tick();
    endtask

    task automatic test_base1();
        logic [31:0] want_i [4] = '{32'h0, 32'h11111111, 32'h22222222, 32'h0};
        logic        want_e [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_recarga();
        beat(32'h11111111, 1'b0);
        beat(32'h22222222, 1'b1);
        n_checks++;
        if (c_tam !== 11'd2 || c_pr !== 1'b1) begin
            n_fail++;
            $display("FAIL base1_load: tam=%0d pr=%b, want 2 1", c_tam, c_pr);
        end
        for (int i = 0; i < 4; i++) begin
            ler      = 1'b1;
            endereco = 32'(i);
            tick();
            n_checks++;
            if (c_instr !== want_i[i] || c_err !== want_e[i] || c_val !== 1'b1) begin
                n_fail++;
                $display("FAIL base1_fetch%0d: instr=%h err=%b val=%b, want %h %b 1",
                         i, c_instr, c_err, c_val, want_i[i], want_e[i]);
            end
        end
        ler = 1'b0;
        tick();
    endtask

    task automatic test_recarga_mid_load();
        do_recarga();
        beat(32'hAAAA0001, 1'b0);
        beat(32'hAAAA0002, 1'b0);
        carga_dado   = 32'hAAAA0003;
        carga_valido = 1'b1;
        recarga      = 1'b1;
        tick();
        carga_valido = 1'b0;
        recarga      = 1'b0;
        n_checks++;
        if (a_tam !== 11'd0 || a_pr !== 1'b0 || a_cp !== 1'b1) begin
            n_fail++;
            $display("FAIL recarga_drop: tam=%0d pr=%b cp=%b, want 0 0 1",
                     a_tam, a_pr, a_cp);
        end
        beat(32'h5EED0001, 1'b1);
        n_checks++;
        if (a_tam !== 11'd1 || a_pr !== 1'b1) begin
            n_fail++;
            $display("FAIL reload1: tam=%0d pr=%b, want 1 1", a_tam, a_pr);
        end
        ler      = 1'b1;
        endereco = 32'd0;
        tick();
        n_checks++;
        if (a_instr !== 32'h5EED0001 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_fetch0: instr=%h err=%b, want 5eed0001 0",
                     a_instr, a_err);
        end
        endereco = 32'd1;
        tick();
        n_checks++;
        if (a_instr !== 32'h0 || a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_fetch1: instr=%h err=%b, want 0 1", a_instr, a_err);
        end
        ler = 1'b0;
    endtask

    task automatic test_async_reset();
        ler      = 1'b1;
        endereco = 32'd0;
        tick();
        ler = 1'b0;
        do_recarga();
        beat(32'h0BAD0001, 1'b0);
        n_checks++;
        if (a_tam !== 11'd1 || a_instr !== 32'h5EED0001) begin
            n_fail++;
            $display("FAIL pre_reset: tam=%0d instr=%h, want 1 5eed0001",
                     a_tam, a_instr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (a_tam !== 11'd0 || a_instr !== 32'h0 || a_pr !== 1'b0 ||
            a_val !== 1'b0 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tam=%0d instr=%h pr=%b val=%b err=%b, want 0s",
                     a_tam, a_instr, a_pr, a_val, a_err);
        end
        reset_n = 1'b1;
        ler      = 1'b1;
        endereco = 32'd0;
        tick();
        ler = 1'b0;
        n_checks++;
        if (a_instr !== 32'h0 || a_err !== 1'b1 || a_val !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_empty: instr=%h err=%b val=%b, want 0 1 1",
                     a_instr, a_err, a_val);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        endereco     = '0;
        ler          = 1'b0;
        carga_dado   = '0;
        carga_valido = 1'b0;
        carga_fim    = 1'b0;
        recarga      = 1'b0;
        test_reset();
        test_load6();
        test_out_of_range();
        test_depth4();
        test_base1();
        test_recarga_mid_load();
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
